// File: rtl/demux_stream_generate.sv
// demux_stream_generate: registered 1-to-N stream demultiplexer.
// One input stream carries a channel select. Each accepted beat is placed in a
// one-entry output register for that channel. Every channel has its own
// valid/ready handshake, so a stalled channel only blocks beats aimed at it.
//
// Parameters:
//   N_OUT    number of output channels (2..16)
//   DW       payload width
//   USE_CASE 1: case-statement select decoder, 0: shift-based decoder (same behaviour)
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_data    input payload
//   in_sel     destination channel of in_data
//   in_valid   input beat present
//   in_ready   beat can be accepted this cycle (combinational)
//   out_data   channel k payload at [k*DW +: DW]
//   out_valid  channel k register holds a beat
//   out_ready  consumer k takes its beat this cycle
//   drop_err   one-cycle pulse after a beat with an out-of-range select was discarded
//   drop_cnt   saturating count of discarded beats
module demux_stream_generate #(
  parameter int unsigned N_OUT    = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned USE_CASE = 0,
  localparam int unsigned SELW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       in_data,
  input  logic [SELW-1:0]     in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic                drop_err,
  output logic [7:0]          drop_cnt
);

  logic [N_OUT-1:0]    dec;
  logic                in_range;
  logic                accept;
  logic                drop;
  logic [N_OUT-1:0]    load;
  logic [N_OUT-1:0]    pop;

  logic [N_OUT-1:0]    valid_q, valid_d;
  logic [N_OUT*DW-1:0] data_q, data_d;
  logic                drop_err_q, drop_err_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  // Select decoder: one-hot of in_sel, all-zero when in_sel >= N_OUT.
  if (USE_CASE != 0) begin : g_case_dec
    always_comb begin
      dec = '0;
      for (int k = 0; k < N_OUT; k++) begin
        case (in_sel)
          SELW'(k): dec[k] = 1'b1;
          default:  ;
        endcase
      end
    end
  end else begin : g_assign_dec
    localparam logic [N_OUT-1:0] OneHot0 = 1;
    // Bits shifted past N_OUT vanish, so out-of-range selects decode to zero.
    assign dec = OneHot0 << in_sel;
  end

  assign in_range = |dec;

  // An occupied channel whose consumer is popping this cycle can still take a beat.
  assign in_ready = in_range ? |(dec & (~valid_q | out_ready)) : 1'b1;
  assign accept   = in_valid & in_ready;
  assign load     = accept ? dec : '0;
  assign pop      = valid_q & out_ready;
  assign drop     = accept & ~in_range;

  always_comb begin
    valid_d = (valid_q & ~pop) | load;
    data_d  = data_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (load[k]) begin
        data_d[k*DW +: DW] = in_data;
      end
    end
    drop_err_d = drop;
    drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      data_q     <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_err  = drop_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream_generate.sv
// Directed and random checks of demux_stream_generate: two N_OUT=4 builds
// (both decoder styles) on shared stimulus and one N_OUT=3 build for drops.
module tb_demux_stream_generate;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic [3:0]  out_ready;

  logic        rdy0, rdy1;
  logic [31:0] od0, od1;
  logic [3:0]  ov0, ov1;
  logic        de0, de1;
  logic [7:0]  dc0, dc1;

  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic [2:0]  out_ready3;
  logic        rdy3;
  logic [23:0] od3;
  logic [2:0]  ov3;
  logic        de3;
  logic [7:0]  dc3;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  demux_stream_generate #(.N_OUT(4), .DW(8), .USE_CASE(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
    .drop_err(de0), .drop_cnt(dc0)
  );

  demux_stream_generate #(.N_OUT(4), .DW(8), .USE_CASE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
    .drop_err(de1), .drop_cnt(dc1)
  );

  demux_stream_generate #(.N_OUT(3), .DW(8), .USE_CASE(1)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(rdy3), .out_data(od3), .out_valid(ov3), .out_ready(out_ready3),
    .drop_err(de3), .drop_cnt(dc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random phase
  logic [7:0] sb [4][$];
  logic [3:0] mvalid;
  logic       exp_rdy;
  logic [7:0] exp_d;
  int         beats;
  int         cycles;

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_sel     = '0;
    in_valid   = 1'b0;
    out_ready  = '0;
    in_data3   = '0;
    in_sel3    = '0;
    in_valid3  = 1'b0;
    out_ready3 = '0;

    // Reset state
    #12;
    chk("rst_ov0", 32'(ov0), 32'h0);
    chk("rst_od0", od0, 32'h0);
    chk("rst_de0", 32'(de0), 32'h0);
    chk("rst_dc0", 32'(dc0), 32'h0);
    chk("rst_ov3", 32'(ov3), 32'h0);
    chk("rst_dc3", 32'(dc3), 32'h0);
    rst = 1'b0;

    // 1: single beat to channel 2, accepted on the first edge after reset
    in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
    #1 chk("t1_rdy", 32'(rdy0), 32'h1);
    step();
    in_valid = 1'b0;
    chk("t1_ov", 32'(ov0), 32'h4);
    chk("t1_od2", 32'(od0[23:16]), 32'hA5);
    chk("t1_ov_case", 32'(ov1), 32'h4);

    // 2: stalled channel 1 blocks only beats aimed at it
    in_sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_data = 8'h77;
    #1 chk("t2_rdy_full", 32'(rdy0), 32'h0);
    chk("t2_rdy_full_case", 32'(rdy1), 32'h0);
    step();
    chk("t2_od1_hold", 32'(od0[15:8]), 32'h3C);
    chk("t2_ov", 32'(ov0), 32'h6);
    in_sel = 2'd3; in_data = 8'h5A;
    #1 chk("t2_rdy_other", 32'(rdy0), 32'h1);
    step();
    in_valid = 1'b0;
    chk("t2_ov3", 32'(ov0), 32'hE);
    chk("t2_od3", 32'(od0[31:24]), 32'h5A);
    chk("t2_od1_still", 32'(od0[15:8]), 32'h3C);

    // 3: pop and load on channel 0 in the same cycle
    in_sel = 2'd0; in_data = 8'h11; in_valid = 1'b1;
    step();
    chk("t3_ov_first", 32'(ov0), 32'hF);
    out_ready = 4'b0001; in_data = 8'h22;
    #1 chk("t3_rdy_pass", 32'(rdy0), 32'h1);
    step();
    in_valid = 1'b0;
    chk("t3_ov_stay", 32'(ov0), 32'hF);
    chk("t3_od0", 32'(od0[7:0]), 32'h22);
    step();
    out_ready = 4'b0000;
    chk("t3_ov_popped", 32'(ov0), 32'hE);
    chk("t3_od0_hold", 32'(od0[7:0]), 32'h22);

    // 5: asynchronous reset mid-cycle with all channels full
    in_sel = 2'd0; in_data = 8'h99; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_ov_full", 32'(ov0), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("t5_ov_async", 32'(ov0), 32'h0);
    chk("t5_od_async", od0, 32'h0);
    chk("t5_ov_async_case", 32'(ov1), 32'h0);
    chk("t5_od_async_case", od1, 32'h0);
    rst = 1'b0;
    step();

    // 4: out-of-range select on the N_OUT=3 build, drop counter saturation
    in_sel3 = 2'd3; in_valid3 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data3 = 8'($urandom);
      #1 chk("t4_rdy", 32'(rdy3), 32'h1);
      step();
      chk("t4_de", 32'(de3), 32'h1);
      chk("t4_dc", 32'(dc3), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      chk("t4_ov", 32'(ov3), 32'h0);
    end
    in_valid3 = 1'b0;
    step();
    chk("t4_de_end", 32'(de3), 32'h0);
    chk("t4_dc_end", 32'(dc3), 32'd255);
    chk("t4_de_pow2", 32'(de0), 32'h0);

    // 6: random traffic on both N_OUT=4 builds against the scoreboard
    mvalid = 4'b0000;
    beats  = 0;
    cycles = 0;
    while (beats < 200 && cycles < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_rdy = !mvalid[in_sel] || out_ready[in_sel];
      chk("r_rdy", 32'(rdy0), 32'(exp_rdy));
      chk("r_rdy_case", 32'(rdy1), 32'(exp_rdy));
      chk("r_ov", 32'(ov0), 32'(mvalid));
      chk("r_ov_case", 32'(ov1), 32'(mvalid));
      chk("r_equiv_od", od1, od0);
      chk("r_de", 32'({de1, de0}), 32'h0);
      for (int k = 0; k < 4; k++) begin
        if (mvalid[k] && out_ready[k]) begin
          exp_d = sb[k].pop_front();
          chk("r_od", 32'(od0[k*8 +: 8]), 32'(exp_d));
          chk("r_od_case", 32'(od1[k*8 +: 8]), 32'(exp_d));
        end
      end
      mvalid = mvalid & ~out_ready;
      if (in_valid && exp_rdy) begin
        sb[in_sel].push_back(in_data);
        mvalid[in_sel] = 1'b1;
        beats++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    chk("r_budget", 32'(beats), 32'd200);

    // Drain everything still held
    out_ready = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (mvalid[k]) begin
        exp_d = sb[k].pop_front();
        chk("d_od", 32'(od0[k*8 +: 8]), 32'(exp_d));
      end
    end
    step();
    chk("d_ov", 32'(ov0), 32'h0);
    chk("d_sb_empty", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
